ysyx_24100005_axil_sram: RTL and testbench
==========================================

// Module: ysyx_24100005_axil_sram
// PURPOSE
//  AXI4-Lite responder backed by a word-addressed SRAM array; serves the core's IFU/LSU initiators.
//  Read and write channels run independent FSMs with programmable response latency.
//  Sits at the bus end opposite the core pipeline, outside the register file.
// PARAMETERS
//  DEPTH     1024  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH-1
//  AW        32    address width
//  LATENCY   1     fixed wait cycles between address accept and response valid (0 allowed)
// PORTS
//  clk      in  1   sole clock, rising edge
//  rst      in  1   synchronous reset, active-low (rst==0 resets on the clk edge)
//  araddr   in  AW  read address;            arvalid in 1; arready out 1
//  rdata    out 32  read data;  rresp out 2; rvalid  out 1; rready  in  1
//  awaddr   in  AW  write address;           awvalid in 1; awready out 1
//  wdata    in  32  write data; wstrb in 4;  wvalid  in 1;  wready  out 1
//  bresp    out 2   write response;          bvalid  out 1; bready  in  1
// BEHAVIOUR
//  Reset: arready=awready=wready=1, rvalid=bvalid=0, rdata=0, rresp=bresp=0; FSMs to IDLE;
//   in-flight transactions dropped; array contents NOT cleared.
//  Index = addr[AW-1:2]; addr[1:0] ignored. Index >= DEPTH -> resp SLVERR(2'b10), rdata=0,
//   no array write. Else OKAY(2'b00).
//  Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   R_IDLE: arready=1; arvalid&arready latches addr; -> R_WAIT (cnt=delay), or R_RESP if delay=0.
//   R_WAIT: arready=0, cnt decrements; at cnt==1 -> R_RESP.
//   R_RESP entry: rdata/rresp registered from array; rvalid=1, held stable until rready; then -> R_IDLE.
//   Accept-to-rvalid = delay+1 cycles; at most one outstanding read.
//  Write FSM W_IDLE -> W_WAIT -> W_RESP:
//   W_IDLE: awready=1 until AW latched, wready=1 until W latched; AW and W in either order or same
//    cycle; leaves W_IDLE once both held (delay counted from the later handshake).
//   W_RESP entry: commit bytes where wstrb[i]=1 (wstrb=0 -> no change, still OKAY); bvalid=1
//    until bready; -> W_IDLE. Handshake-to-bvalid = delay+1 cycles.
//  Same-edge hazard: read capture and write commit to same word on one edge -> read returns OLD data.
//  rready/bready asserted before valid: no effect. Valids never drop without handshake.
// CONFIGURATION
//  SRAM_RAND_DELAY_EN defined: delay per transaction = lfsr[1:0] (0..3), LATENCY ignored; 4-bit
//   Fibonacci LFSR x^4+x^3+1, seed 4'b1001 on reset, advances every cycle; read and write sample it
//   at their own accept edge.
//  Undefined: delay = LATENCY for every transaction; no LFSR logic.
// STRUCTURE
//  Package ysyx_24100005_axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, read/write state encodings.
//  Sub-module ysyx_24100005_lfsr4 (clk, rst, q[3:0]) instantiated only under SRAM_RAND_DELAY_EN.
//  Array: reg [31:0] mem [0:DEPTH-1], byte-lane write.
// TESTING
//  1 Write 0x10 data 0xDEADBEEF wstrb 4'hF, LATENCY=1 -> bvalid 2 cycles after handshake, bresp 0;
//    read 0x10 -> rdata 0xDEADBEEF.
//  2 W before AW by 3 cycles, wstrb 4'b0010 data 0x0000AB00 onto 0x11223344 -> reads 0x1122AB44.
//  3 Read addr 4*DEPTH -> rresp 2'b10, rdata 0; write there -> bresp 2'b10, array unchanged.
//  4 Hold rready=0 for 5 cycles after rvalid -> rdata/rvalid stable; arready stays 0 until handshake.
//  5 rst=0 while in R_WAIT and W_RESP -> next cycle rvalid=bvalid=0, all readys 1; prior data kept.
//  6 SRAM_RAND_DELAY_EN: 100 random reads/writes -> every delay in 0..3 observed, data matches model.

Source files
------------

// File: rtl/ysyx_24100005_axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// read/write FSM state encodings and the latency counter width.
package ysyx_24100005_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Wide enough for any practical fixed LATENCY setting.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

endpackage

// File: rtl/ysyx_24100005_lfsr4.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1), seeded with 4'b1001 on reset and
// stepping every cycle. Supplies per-transaction response delays when the
// SRAM is built with SRAM_RAND_DELAY_EN.
module ysyx_24100005_lfsr4 (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] q
);

  // Shift left, feeding back the XOR of the two taps into bit 0.
  always_ff @(posedge clk) begin
    if (!rst) q <= 4'b1001;
    else      q <= {q[2:0], q[3] ^ q[2]};
  end

endmodule

// File: rtl/ysyx_24100005_axil_sram.sv
// AXI4-Lite responder backed by a word-addressed SRAM. Independent read and
// write FSMs, each inserting a response delay between address acceptance and
// the response. Build option SRAM_RAND_DELAY_EN: the delay comes from a 4-bit
// LFSR (0..3 per transaction) instead of the fixed LATENCY parameter.
module ysyx_24100005_axil_sram
  import ysyx_24100005_axil_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] araddr,
  input  logic          arvalid,
  output logic          arready,
  output logic [31:0]   rdata,
  output logic [1:0]    rresp,
  output logic          rvalid,
  input  logic          rready,
  input  logic [AW-1:0] awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          wvalid,
  output logic          wready,
  output logic [1:0]    bresp,
  output logic          bvalid,
  input  logic          bready
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [0:DEPTH-1];

  logic [CNT_W-1:0] delay;

  function automatic logic in_range(input logic [AW-3:0] idx);
    return {2'b00, idx} < AW'(DEPTH);
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_q;
  ysyx_24100005_lfsr4 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );
  assign delay = {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
  logic unused_lfsr;
  assign unused_lfsr = &{1'b0, lfsr_q[3:2]};
`else
  assign delay = CNT_W'(LATENCY);
`endif

  // Byte offset bits are ignored: accesses are always whole words.
  logic unused_addr;
  assign unused_addr = &{1'b0, araddr[1:0], awaddr[1:0]};

  // ---------------------------------------------------------------- read path
  r_state_e         r_q, r_d;
  logic [CNT_W-1:0] r_cnt_q;
  logic [AW-3:0]    r_idx_q;
  logic [AW-3:0]    rd_idx;

  // With zero delay the capture happens on the accept edge, so use the live address.
  assign rd_idx = (r_q == R_IDLE) ? araddr[AW-1:2] : r_idx_q;

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_d     = r_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_d = (delay == '0) ? R_RESP : R_WAIT;
      end
      R_WAIT: if (r_cnt_q == CNT_W'(1)) r_d = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_d = R_IDLE;
      end
      default: r_d = R_IDLE;
    endcase
  end

  // Read state, delay counter, and response capture on entry to R_RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q     <= R_IDLE;
      r_cnt_q <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_q <= r_d;
      if (r_q == R_IDLE && arvalid) begin
        r_idx_q <= araddr[AW-1:2];
        r_cnt_q <= delay;
      end else if (r_q == R_WAIT) begin
        r_cnt_q <= r_cnt_q - 1'b1;
      end
      if (r_d == R_RESP && r_q != R_RESP) begin
        if (in_range(rd_idx)) begin
          rdata <= mem[rd_idx[IW-1:0]];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // --------------------------------------------------------------- write path
  w_state_e         w_q, w_d;
  logic [CNT_W-1:0] w_cnt_q;
  logic             aw_held_q, w_held_q;
  logic [AW-3:0]    w_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             aw_hs, w_hs, both_held, commit;
  logic [AW-3:0]    wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign both_held = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  // Zero delay commits on the later handshake edge, so forward live channel values.
  assign wr_idx    = aw_hs ? awaddr[AW-1:2] : w_idx_q;
  assign wr_data   = w_hs ? wdata : w_data_q;
  assign wr_strb   = w_hs ? wstrb : w_strb_q;
  assign commit    = (w_d == W_RESP) && (w_q != W_RESP);

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_d     = w_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_q)
      W_IDLE: begin
        awready = !aw_held_q;
        wready  = !w_held_q;
        if (both_held) w_d = (delay == '0) ? W_RESP : W_WAIT;
      end
      W_WAIT: if (w_cnt_q == CNT_W'(1)) w_d = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  // Write state, channel capture, delay counter and response code.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q       <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_cnt_q   <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_q <= w_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        w_idx_q   <= awaddr[AW-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (w_q == W_IDLE && both_held) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        w_cnt_q   <= delay;
      end else if (w_q == W_WAIT) begin
        w_cnt_q <= w_cnt_q - 1'b1;
      end
      if (commit) bresp <= in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Byte-lane commit on entry to W_RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && commit && in_range(wr_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx[IW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_axil_sram.sv
// Self-checking bench for ysyx_24100005_axil_sram (DEPTH=16, LATENCY=1).
module tb_ysyx_24100005_axil_sram;

  localparam int DEPTH   = 16;
  localparam int AW      = 32;
  localparam int LATENCY = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;

  ysyx_24100005_axil_sram #(.DEPTH(DEPTH), .AW(AW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit seen_delay [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_lat(input string name, input int lat);
`ifdef SRAM_RAND_DELAY_EN
    chk(name, 32'(lat >= 1 && lat <= 4), 32'd1);
    if (lat >= 1 && lat <= 4) seen_delay[lat-1] = 1'b1;
`else
    chk(name, 32'(lat), 32'(LATENCY + 1));
`endif
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // AW and W presented from cycle aw_start / w_start; lat = cycles from later handshake to bvalid.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_start, input int w_start,
                           output logic [1:0] resp, output int lat, output bit rdy_ok);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int c = 0;
    rdy_ok = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      awaddr  = a;  wdata = d;  wstrb = s;
      awvalid = (c >= aw_start) && !aw_done;
      wvalid  = (c >= w_start) && !w_done;
      @(negedge clk);
      if ((aw_done && awready) || (w_done && wready)) rdy_ok = 1'b0;
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      step();
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("w_handshake", 32'(aw_done && w_done), 32'd1);
    lat = 1;
    while (!bvalid && lat < 50) begin step(); lat++; end
    resp   = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  // Read; optionally hold rready low for `hold` cycles after rvalid, or raise it early.
  task automatic read_txn(input logic [31:0] a, input int hold, input bit pre,
                          output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output bit stable);
    bit got = 1'b0;
    int c = 0;
    rready  = pre;
    araddr  = a;
    arvalid = 1'b1;
    while (!got && c < 50) begin
      @(negedge clk);
      got = arready;
      step();
      c++;
    end
    arvalid = 1'b0;
    chk("ar_handshake", 32'(got), 32'd1);
    lat = 1;
    while (!rvalid && lat < 50) begin step(); lat++; end
    d      = rdata;
    resp   = rresp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rvalid || rdata !== d || rresp !== resp || arready) stable = 1'b0;
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_start;
    int          w_start;
    logic [31:0] raddr;
    int          hold;
    bit          pre;
    logic [1:0]  exp_b;
    logic [31:0] exp_rd;
    logic [1:0]  exp_r;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] model [DEPTH];

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    bit          ok;

    vecs[0]  = '{32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h10, 0, 1'b0, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1]  = '{32'h14, 32'h11223344, 4'hF, 0, 0, 32'h14, 0, 1'b0, 2'b00, 32'h11223344, 2'b00};
    vecs[2]  = '{32'h14, 32'h0000AB00, 4'b0010, 3, 0, 32'h14, 0, 1'b0, 2'b00, 32'h1122AB44, 2'b00};
    vecs[3]  = '{32'h17, 32'h55667788, 4'b1001, 0, 2, 32'h14, 0, 1'b0, 2'b00, 32'h5522AB88, 2'b00};
    vecs[4]  = '{32'h18, 32'hCAFEF00D, 4'hF, 1, 1, 32'h18, 0, 1'b1, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[5]  = '{32'h18, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h18, 0, 1'b0, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[6]  = '{32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h00, 0, 1'b0, 2'b00, 32'hA5A5A5A5, 2'b00};
    vecs[7]  = '{32'h40, 32'h12345678, 4'hF, 0, 0, 32'h40, 0, 1'b0, 2'b10, 32'h00000000, 2'b10};
    vecs[8]  = '{32'h3C, 32'h0BADC0DE, 4'hF, 0, 0, 32'h00, 0, 1'b0, 2'b00, 32'hA5A5A5A5, 2'b00};
    vecs[9]  = '{32'hFFFFFFFC, 32'h87654321, 4'hF, 0, 0, 32'h3C, 0, 1'b0, 2'b10, 32'h0BADC0DE, 2'b00};
    vecs[10] = '{32'h1C, 32'h01020304, 4'hF, 0, 0, 32'h10, 5, 1'b0, 2'b00, 32'hDEADBEEF, 2'b00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_resp",    32'({rresp, bresp}), 32'd0);
    rst = 1'b1;
    step();

    // Directed vectors: write then read back
    for (int i = 0; i < 11; i++) begin
      write_txn(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].aw_start, vecs[i].w_start,
                resp, lat, ok);
      chk($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_b));
      chk_lat($sformatf("v%0d_wlat", i), lat);
      chk($sformatf("v%0d_wready_hold", i), 32'(ok), 32'd1);
      read_txn(vecs[i].raddr, vecs[i].hold, vecs[i].pre, d, resp, lat, ok);
      chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rd);
      chk($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_r));
      chk_lat($sformatf("v%0d_rlat", i), lat);
      chk($sformatf("v%0d_r_stable", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_rvalid_clr", i), 32'(rvalid), 32'd0);
    end

`ifndef SRAM_RAND_DELAY_EN
    // Same-edge hazard: read capture and write commit to one word -> old data
    write_txn(32'h20, 32'h11111111, 4'hF, 0, 0, resp, lat, ok);
    araddr = 32'h20; arvalid = 1'b1;
    awaddr = 32'h20; awvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("haz_rvalid", 32'(rvalid), 32'd1);
    chk("haz_bvalid", 32'(bvalid), 32'd1);
    chk("haz_old_data", rdata, 32'h11111111);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    read_txn(32'h20, 0, 1'b0, d, resp, lat, ok);
    chk("haz_new_data", d, 32'h22222222);
`endif

    // Reset while the read waits and the write holds its response
    write_txn(32'h24, 32'h33333333, 4'hF, 0, 0, resp, lat, ok);
    awaddr = 32'h28; wdata = 32'h44444444; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h24; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
`ifndef SRAM_RAND_DELAY_EN
    chk("mid_bvalid", 32'(bvalid), 32'd1);
    chk("mid_arready", 32'(arready), 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("rst2_rvalid",  32'(rvalid),  32'd0);
    chk("rst2_bvalid",  32'(bvalid),  32'd0);
    chk("rst2_readys",  32'({arready, awready, wready}), 32'h7);
    chk("rst2_rdata",   rdata, 32'd0);
    rst = 1'b1;
    step();
    read_txn(32'h24, 0, 1'b0, d, resp, lat, ok);
    chk("rst2_kept", d, 32'h33333333);
`ifndef SRAM_RAND_DELAY_EN
    read_txn(32'h28, 0, 1'b0, d, resp, lat, ok);
    chk("rst2_committed", d, 32'h44444444);
`endif

    // Random traffic against a word model
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = $urandom;
      write_txn(32'(4 * i), model[i], 4'hF, 0, 0, resp, lat, ok);
    end
    for (int n = 0; n < 100; n++) begin
      int          idx;
      logic [31:0] wd;
      logic [3:0]  st;
      idx = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        st = 4'($urandom_range(0, 15));
        write_txn(32'(4 * idx), wd, st, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat, ok);
        for (int b = 0; b < 4; b++) if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        chk($sformatf("rnd%0d_bresp", n), 32'(resp), 32'd0);
        chk_lat($sformatf("rnd%0d_wlat", n), lat);
      end else begin
        read_txn(32'(4 * idx), 0, 1'b0, d, resp, lat, ok);
        chk($sformatf("rnd%0d_rdata", n), d, model[idx]);
        chk_lat($sformatf("rnd%0d_rlat", n), lat);
      end
    end
`ifdef SRAM_RAND_DELAY_EN
    for (int k = 0; k < 4; k++) chk($sformatf("delay_%0d_seen", k), 32'(seen_delay[k]), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
